cmd_issue_queue: RTL and testbench

- Host-side request buffer that sits directly upstream of the SD command block.
- Accepts command requests (index, argument, timeout enable) from host logic into a FIFO.
- Issues requests one at a time to the command block (iNew_command/iCmd_index/iCmd_argument/iTimeout_enable) and waits for completion.
- Captures the 48-bit response and termination status into a response slot that host logic must acknowledge; a watchdog guards against a hung transaction.

---
 rtl/cmd_issue_queue.sv | 167 ++++++++++++++++
 tb/tb_cmd_issue_queue.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cmd_issue_queue.sv
// Request FIFO in front of the SD command block. Issues one command at a time,
// waits for it to terminate, and holds the result until the host acknowledges it.
module cmd_issue_queue #(
  parameter int DEPTH           = 4,
  parameter int AW              = 2,
  parameter int WATCHDOG_CYCLES = 1024
) (
  input  logic          iClock_host,
  input  logic          iReset,
  input  logic          iPush,
  input  logic [5:0]    iPush_index,
  input  logic [31:0]   iPush_argument,
  input  logic          iPush_timeout_enable,
  output logic          oFull,
  output logic          oEmpty,
  output logic [AW:0]   oCount,
  output logic          oOverflow,
  output logic          oNew_command,
  output logic [5:0]    oCmd_index,
  output logic [31:0]   oCmd_argument,
  output logic          oTimeout_enable,
  input  logic          iCommand_complete,
  input  logic          iCommand_index_error,
  input  logic [47:0]   iResponse,
  output logic          oResp_valid,
  output logic [47:0]   oResponse,
  output logic [5:0]    oResp_index,
  output logic [1:0]    oResp_status,
  input  logic          iResp_ack,
  output logic          oBusy
);
  localparam int              WDW      = $clog2(WATCHDOG_CYCLES);
  localparam logic [WDW-1:0]  WD_LAST  = WDW'(WATCHDOG_CYCLES - 1);
  localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic        te;
  } req_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  req_t           mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  state_t         state_q, state_d;
  req_t           cmd_q, cmd_d;
  logic           new_cmd_q, new_cmd_d;
  logic           ovf_q, ovf_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic           resp_valid_q, resp_valid_d;
  logic [47:0]    resp_q, resp_d;
  logic [5:0]     resp_idx_q, resp_idx_d;
  logic [1:0]     status_q, status_d;

  logic full, push_ok, pop;
  req_t req_in;

  assign full    = (count_q == FULL_CNT);
  // Full is judged on the registered count, so a same-cycle pop never frees room.
  assign push_ok = iPush && !full;
  assign pop     = (state_q == IDLE) && (count_q != '0) && !resp_valid_q;
  assign req_in  = '{idx: iPush_index, arg: iPush_argument, te: iPush_timeout_enable};

  always_ff @(posedge iClock_host) begin
    if (push_ok) mem_q[wr_ptr_q] <= req_in;
  end

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    new_cmd_d    = 1'b0;
    wd_d         = wd_q;
    resp_valid_d = resp_valid_q;
    resp_d       = resp_q;
    resp_idx_d   = resp_idx_q;
    status_d     = status_q;
    ovf_d        = iPush && full;
    wr_ptr_d     = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d     = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase

    if (iResp_ack && resp_valid_q) resp_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pop) begin
          state_d   = ISSUE;
          cmd_d     = mem_q[rd_ptr_q];
          new_cmd_d = 1'b1;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        wd_d    = '0;
      end
      WAIT: begin
        wd_d = wd_q + WDW'(1);
        if (iCommand_index_error || iCommand_complete || (wd_q == WD_LAST)) begin
          state_d      = IDLE;
          resp_valid_d = 1'b1;
          resp_idx_d   = cmd_q.idx;
          if (iCommand_index_error) begin
            status_d = 2'b01;
            resp_d   = iResponse;
          end else if (iCommand_complete) begin
            status_d = 2'b00;
            resp_d   = iResponse;
          end else begin
            status_d = 2'b10;
            resp_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClock_host or negedge iReset) begin
    if (!iReset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      cmd_q        <= '0;
      new_cmd_q    <= 1'b0;
      ovf_q        <= 1'b0;
      wd_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_q       <= '0;
      resp_idx_q   <= '0;
      status_q     <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      cmd_q        <= cmd_d;
      new_cmd_q    <= new_cmd_d;
      ovf_q        <= ovf_d;
      wd_q         <= wd_d;
      resp_valid_q <= resp_valid_d;
      resp_q       <= resp_d;
      resp_idx_q   <= resp_idx_d;
      status_q     <= status_d;
    end
  end

  assign oFull           = full;
  assign oEmpty          = (count_q == '0);
  assign oCount          = count_q;
  assign oOverflow       = ovf_q;
  assign oNew_command    = new_cmd_q;
  assign oCmd_index      = cmd_q.idx;
  assign oCmd_argument   = cmd_q.arg;
  assign oTimeout_enable = cmd_q.te;
  assign oResp_valid     = resp_valid_q;
  assign oResponse       = resp_q;
  assign oResp_index     = resp_idx_q;
  assign oResp_status    = status_q;
  assign oBusy           = (state_q != IDLE);
endmodule

// File: tb/tb_cmd_issue_queue.sv
// Bench for cmd_issue_queue: directed scenarios plus random traffic, every cycle
// compared against a queue-based transaction model.
module tb_cmd_issue_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int WC    = 16;

  typedef struct packed {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic        te;
  } req_t;

  logic        clk = 1'b0;
  logic        iReset;
  logic        iPush;
  logic [5:0]  iPush_index;
  logic [31:0] iPush_argument;
  logic        iPush_timeout_enable;
  logic        oFull, oEmpty, oOverflow, oNew_command, oTimeout_enable;
  logic [AW:0] oCount;
  logic [5:0]  oCmd_index, oResp_index;
  logic [31:0] oCmd_argument;
  logic        iCommand_complete, iCommand_index_error, iResp_ack;
  logic [47:0] iResponse, oResponse;
  logic        oResp_valid, oBusy;
  logic [1:0]  oResp_status;

  always #5 clk = ~clk;

  cmd_issue_queue #(.DEPTH(DEPTH), .AW(AW), .WATCHDOG_CYCLES(WC)) dut (
    .iClock_host(clk), .iReset(iReset),
    .iPush(iPush), .iPush_index(iPush_index), .iPush_argument(iPush_argument),
    .iPush_timeout_enable(iPush_timeout_enable),
    .oFull(oFull), .oEmpty(oEmpty), .oCount(oCount), .oOverflow(oOverflow),
    .oNew_command(oNew_command), .oCmd_index(oCmd_index), .oCmd_argument(oCmd_argument),
    .oTimeout_enable(oTimeout_enable),
    .iCommand_complete(iCommand_complete), .iCommand_index_error(iCommand_index_error),
    .iResponse(iResponse),
    .oResp_valid(oResp_valid), .oResponse(oResponse), .oResp_index(oResp_index),
    .oResp_status(oResp_status), .iResp_ack(iResp_ack), .oBusy(oBusy)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Transaction model: queue of pending requests, one in-flight command aged
  // in cycles since issue, and a single response slot.
  req_t        fq[$];
  req_t        m_cmd;
  bit          m_inflight, m_newcmd, m_ovf, m_sv;
  int          m_age;
  logic [47:0] m_resp;
  logic [5:0]  m_ridx;
  logic [1:0]  m_rst;

  task automatic model_reset();
    fq.delete();
    m_cmd = '0; m_inflight = 0; m_newcmd = 0; m_ovf = 0; m_sv = 0;
    m_age = 0; m_resp = '0; m_ridx = '0; m_rst = '0;
  endtask

  task automatic finish_cmd(input logic [1:0] st, input logic [47:0] r);
    m_sv = 1; m_rst = st; m_resp = r; m_ridx = m_cmd.idx; m_inflight = 0;
  endtask

  task automatic model_step();
    bit full0, sv0;
    req_t nr;
    full0 = (fq.size() == DEPTH);
    sv0   = m_sv;
    nr    = '{idx: iPush_index, arg: iPush_argument, te: iPush_timeout_enable};
    m_ovf    = iPush && full0;
    m_newcmd = 0;
    if (iResp_ack && sv0) m_sv = 0;
    if (m_inflight) begin
      // age 0 is the issue-strobe cycle; terminations are only seen afterwards
      if (m_age == 0) m_age = 1;
      else if (iCommand_index_error) finish_cmd(2'b01, iResponse);
      else if (iCommand_complete) finish_cmd(2'b00, iResponse);
      else if (m_age == WC) finish_cmd(2'b10, '0);
      else m_age++;
    end else if (fq.size() > 0 && !sv0) begin
      m_cmd = fq.pop_front(); m_inflight = 1; m_age = 0; m_newcmd = 1;
    end
    if (iPush && !full0) fq.push_back(nr);
  endtask

  always @(posedge clk) begin
    if (!iReset) model_reset();
    else model_step();
  end

  task automatic check_all();
    chk("count",     64'(oCount),          64'(fq.size()));
    chk("full",      64'(oFull),           64'(fq.size() == DEPTH));
    chk("empty",     64'(oEmpty),          64'(fq.size() == 0));
    chk("overflow",  64'(oOverflow),       64'(m_ovf));
    chk("new_cmd",   64'(oNew_command),    64'(m_newcmd));
    chk("cmd_idx",   64'(oCmd_index),      64'(m_cmd.idx));
    chk("cmd_arg",   64'(oCmd_argument),   64'(m_cmd.arg));
    chk("cmd_te",    64'(oTimeout_enable), 64'(m_cmd.te));
    chk("rsp_valid", 64'(oResp_valid),     64'(m_sv));
    chk("response",  64'(oResponse),       64'(m_resp));
    chk("rsp_idx",   64'(oResp_index),     64'(m_ridx));
    chk("rsp_stat",  64'(oResp_status),    64'(m_rst));
    chk("busy",      64'(oBusy),           64'(m_inflight));
  endtask

  function automatic logic [47:0] rnd48();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[47:0];
  endfunction

  task automatic step(input bit push, input logic [5:0] idx, input logic [31:0] arg,
                      input bit te, input bit cc, input bit ie,
                      input logic [47:0] rsp, input bit ack);
    iPush = push; iPush_index = idx; iPush_argument = arg; iPush_timeout_enable = te;
    iCommand_complete = cc; iCommand_index_error = ie; iResponse = rsp; iResp_ack = ack;
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  // Idle traffic that terminates the in-flight command at a chosen age.
  task automatic run(input int n, input int cc_age, input int ie_age, input bit ack_en);
    for (int i = 0; i < n; i++)
      step(0, 6'($urandom()), $urandom(), 1'($urandom()),
           (cc_age > 0) && m_inflight && (m_age == cc_age),
           (ie_age > 0) && m_inflight && (m_age == ie_age),
           rnd48(), ack_en && m_sv);
  endtask

  initial begin
    iReset = 1'b0;
    iPush = 0; iPush_index = '0; iPush_argument = '0; iPush_timeout_enable = 0;
    iCommand_complete = 0; iCommand_index_error = 0; iResponse = '0; iResp_ack = 0;
    model_reset();
    @(negedge clk);
    check_all();
    step(0, 0, 0, 0, 0, 0, '0, 0);
    iReset = 1'b1;

    // single command, completion 5 cycles after the issue strobe
    step(1, 6'd17, 32'h0000_1234, 1, 0, 0, '0, 0);
    run(1, 0, 0, 0);
    run(4, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 48'h11_0000_0900_AB, 0);
    run(2, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, '0, 1);
    run(2, 0, 0, 0);

    // overflow: six back-to-back pushes, slot left unacked, then drain
    for (int i = 1; i <= 6; i++) step(1, 6'(i), 32'(i * 16), 1'(i), 0, 0, '0, 0);
    run(10, 3, 0, 0);
    run(60, 3, 0, 1);

    // index error blocks the next issue until ack
    step(1, 6'd40, 32'hDEAD_BEEF, 0, 0, 0, '0, 0);
    step(1, 6'd41, 32'hCAFE_F00D, 1, 0, 0, '0, 0);
    run(12, 0, 3, 0);
    run(20, 4, 0, 1);

    // watchdog expiry, then completion / index error on the expiry edge
    step(1, 6'd50, 32'h5, 1, 0, 0, '0, 0);
    run(25, 0, 0, 1);
    step(1, 6'd51, 32'h6, 1, 0, 0, '0, 0);
    run(25, WC, 0, 1);
    step(1, 6'd52, 32'h7, 0, 0, 0, '0, 0);
    run(25, 0, WC, 1);

    // asynchronous reset during WAIT with two entries queued
    for (int i = 0; i < 3; i++) step(1, 6'(20 + i), 32'(i), 1, 0, 0, '0, 0);
    run(3, 0, 0, 0);
    #2 iReset = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clk);
    check_all();
    step(0, 0, 0, 0, 1, 0, rnd48(), 1);
    iReset = 1'b1;
    run(5, 0, 0, 1);
    step(1, 6'd33, 32'h3333, 1, 0, 0, '0, 0);
    run(12, 4, 0, 1);

    // pointer wrap-around
    for (int i = 0; i < 10; i++) begin
      step(1, 6'(i + 1), $urandom(), 1'($urandom()), 0, 0, '0, 0);
      run(8, 3, 0, 1);
    end

    // random traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(99) < 40, 6'($urandom()), $urandom(), 1'($urandom()),
           $urandom_range(99) < 12, $urandom_range(99) < 4, rnd48(),
           $urandom_range(99) < 30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
